// File: rtl/nibble_compare_seq_pkg.sv
// Shared constants for the sequential nibble comparator: state encoding and nibble width.
package nibble_compare_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_compare_seq_cmp4_unit.sv
// Purely combinational 4-bit unsigned magnitude comparator built from gate primitives.
module cmp4_unit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       lt,
    output logic       gt,
    output logic       eq
);

    wire [3:0] bit_eq;
    wire [3:0] a_n;
    wire [3:0] b_n;
    wire       gt3, gt2, gt1, gt0;
    wire       lt3, lt2, lt1, lt0;

    xnor u_xn3 (bit_eq[3], a[3], b[3]);
    xnor u_xn2 (bit_eq[2], a[2], b[2]);
    xnor u_xn1 (bit_eq[1], a[1], b[1]);
    xnor u_xn0 (bit_eq[0], a[0], b[0]);

    not u_na3 (a_n[3], a[3]);
    not u_na2 (a_n[2], a[2]);
    not u_na1 (a_n[1], a[1]);
    not u_na0 (a_n[0], a[0]);
    not u_nb3 (b_n[3], b[3]);
    not u_nb2 (b_n[2], b[2]);
    not u_nb1 (b_n[1], b[1]);
    not u_nb0 (b_n[0], b[0]);

    // A bit position decides only when every more significant bit matched.
    and u_g3 (gt3, a[3], b_n[3]);
    and u_g2 (gt2, bit_eq[3], a[2], b_n[2]);
    and u_g1 (gt1, bit_eq[3], bit_eq[2], a[1], b_n[1]);
    and u_g0 (gt0, bit_eq[3], bit_eq[2], bit_eq[1], a[0], b_n[0]);
    or  u_gt (gt, gt3, gt2, gt1, gt0);

    and u_l3 (lt3, a_n[3], b[3]);
    and u_l2 (lt2, bit_eq[3], a_n[2], b[2]);
    and u_l1 (lt1, bit_eq[3], bit_eq[2], a_n[1], b[1]);
    and u_l0 (lt0, bit_eq[3], bit_eq[2], bit_eq[1], a_n[0], b[0]);
    or  u_lt (lt, lt3, lt2, lt1, lt0);

    and u_eq (eq, bit_eq[3], bit_eq[2], bit_eq[1], bit_eq[0]);

endmodule

// File: rtl/nibble_compare_seq.sv
// Wide unsigned compare done one nibble per cycle from the MSB, sharing a single 4-bit comparator.
module nibble_compare_seq
    import nibble_compare_seq_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int CNT_W   = $clog2(NIBBLES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic                     a_lt_b,
    output logic                     a_gt_b,
    output logic                     a_eq_b,
    output logic [CNT_W-1:0]         nib_cnt
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state;
    state_t             next_state;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [IDX_W-1:0]   idx;
    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic               cmp_lt;
    logic               cmp_gt;
    logic               cmp_eq;
    logic               accept;
    logic               finish;

    // Select the nibble currently under examination.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_a = a_reg[i*NIB_W +: NIB_W];
                nib_b = b_reg[i*NIB_W +: NIB_W];
            end
        end
    end

    cmp4_unit u_cmp (
        .a  (nib_a),
        .b  (nib_b),
        .lt (cmp_lt),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                busy = 1'b1;
                // The first unequal nibble settles it; otherwise the last nibble does.
                if (!cmp_eq || idx == '0) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            idx     <= '0;
            done    <= 1'b0;
            a_lt_b  <= 1'b0;
            a_gt_b  <= 1'b0;
            a_eq_b  <= 1'b0;
            nib_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_reg   <= a;
                b_reg   <= b;
                idx     <= IDX_W'(NIBBLES - 1);
                a_lt_b  <= 1'b0;
                a_gt_b  <= 1'b0;
                a_eq_b  <= 1'b0;
                nib_cnt <= '0;
            end else if (state == COMPARE) begin
                nib_cnt <= nib_cnt + CNT_W'(1);
                if (finish) begin
                    a_lt_b <= cmp_lt;
                    a_gt_b <= cmp_gt;
                    a_eq_b <= cmp_eq;
                    done   <= 1'b1;
                end else begin
                    idx <= idx - IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_compare_seq.sv
// Self-checking bench: vector table, hand-written corner sequences and random compares against a model.
module tb_nibble_compare_seq;

    localparam int NIBBLES = 4;
    localparam int CNT_W   = $clog2(NIBBLES + 1);
    localparam int W       = 4 * NIBBLES;
    localparam int TIMEOUT = 40;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         lt;
        logic         gt;
        logic         eq;
        int           cnt;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic             a_lt_b;
    logic             a_gt_b;
    logic             a_eq_b;
    logic [CNT_W-1:0] nib_cnt;

    int checks;
    int errors;

    nibble_compare_seq #(.NIBBLES(NIBBLES), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .a_lt_b  (a_lt_b),
        .a_gt_b  (a_gt_b),
        .a_eq_b  (a_eq_b),
        .nib_cnt (nib_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected outcome from plain arithmetic: flags from whole-operand compare,
    // nibble count from the first differing nibble scanning down from the MSB.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output vec_t exp);
        int first;
        first = NIBBLES;
        for (int k = 0; k < NIBBLES; k++) begin
            int sh;
            sh = 4 * (NIBBLES - 1 - k);
            if (first == NIBBLES && ((ma >> sh) & 15) != ((mb >> sh) & 15)) first = k + 1;
        end
        exp.a   = ma;
        exp.b   = mb;
        exp.lt  = (ma < mb);
        exp.gt  = (ma > mb);
        exp.eq  = (ma == mb);
        exp.cnt = first;
    endtask

    // Called right after the accepting edge; returns cycles until done is seen.
    task automatic waitDone(input int drop_k, output int m, output int busy_err,
                            output int flag_err);
        m        = -1;
        busy_err = 0;
        flag_err = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            if (k == drop_k) start = 1'b0;
            if (done) begin
                m = k;
                break;
            end
            if (!busy) busy_err++;
            if (a_lt_b || a_gt_b || a_eq_b) flag_err++;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] sa, input logic [W-1:0] sb,
                                 output int m, output int busy_err, output int flag_err);
        @(negedge clk);
        a     = sa;
        b     = sb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(-1, m, busy_err, flag_err);
    endtask

    task automatic checkResult(input string tag, input vec_t exp, input int m,
                               input int busy_err, input int flag_err);
        checkOutput({tag, " latency"}, m, exp.cnt);
        checkOutput({tag, " lt"}, int'(a_lt_b), int'(exp.lt));
        checkOutput({tag, " gt"}, int'(a_gt_b), int'(exp.gt));
        checkOutput({tag, " eq"}, int'(a_eq_b), int'(exp.eq));
        checkOutput({tag, " nib_cnt"}, int'(nib_cnt), exp.cnt);
        checkOutput({tag, " busy_at_done"}, int'(busy), 0);
        checkOutput({tag, " busy_drop"}, busy_err, 0);
        checkOutput({tag, " flags_while_busy"}, flag_err, 0);
        @(negedge clk);
        checkOutput({tag, " done_width"}, int'(done), 0);
    endtask

    vec_t vecs[$];
    vec_t exp;
    int   m, busy_err, flag_err, done_cnt;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        vecs.push_back('{16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{16'h1234, 16'h1235, 1'b1, 1'b0, 1'b0, 4});
        vecs.push_back('{16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b1, 4});
        vecs.push_back('{16'h00F0, 16'h00E0, 1'b0, 1'b1, 1'b0, 3});
        vecs.push_back('{16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 4});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4});
        vecs.push_back('{16'hFFFF, 16'h0FFF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{16'h1200, 16'h1300, 1'b1, 1'b0, 1'b0, 2});

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", int'({busy, done, a_lt_b, a_gt_b, a_eq_b, nib_cnt}), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, m, busy_err, flag_err);
            checkResult($sformatf("vec%0d", i), vecs[i], m, busy_err, flag_err);
        end

        // Reset one cycle into a compare: everything clears immediately, no done follows.
        @(negedge clk);
        a     = 16'h1234;
        b     = 16'h1235;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_outputs", int'({busy, done, a_lt_b, a_gt_b, a_eq_b, nib_cnt}), 0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        checkOutput("mid_reset_no_done", done_cnt, 0);
        model(16'hA5A5, 16'hA5C5, exp);
        applyStimulus(16'hA5A5, 16'hA5C5, m, busy_err, flag_err);
        checkResult("after_reset", exp, m, busy_err, flag_err);

        // Operand change and start pulses while busy must not disturb the compare.
        @(negedge clk);
        a     = 16'h00F0;
        b     = 16'h00E0;
        start = 1'b1;
        @(posedge clk);
        #1 a = 16'h0000;
        waitDone(1, m, busy_err, flag_err);
        model(16'h00F0, 16'h00E0, exp);
        checkOutput("ignored_latency", m, 3);
        checkOutput("ignored_gt", int'(a_gt_b), 1);
        checkOutput("ignored_cnt", int'(nib_cnt), 3);
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        checkOutput("ignored_single_done", done_cnt, 0);

        // Back-to-back: new start driven during the done cycle.
        applyStimulus(16'h5000, 16'h5100, m, busy_err, flag_err);
        checkOutput("b2b_first_latency", m, 2);
        a     = 16'h0001;
        b     = 16'h0002;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("b2b_flags_cleared", int'({a_lt_b, a_gt_b, a_eq_b}), 0);
        checkOutput("b2b_busy", int'(busy), 1);
        waitDone(-1, m, busy_err, flag_err);
        model(16'h0001, 16'h0002, exp);
        checkResult("b2b_second", exp, m, busy_err, flag_err);

        // Random compares, half of them sharing a prefix so deep latencies are exercised.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ra;
            if (n % 2 == 0) begin
                rb = W'($urandom);
            end else if (n % 5 != 0) begin
                int pos;
                pos = $urandom_range(NIBBLES - 1, 0);
                rb  = ra ^ (W'($urandom_range(15, 1)) << (4 * pos));
                rb  = rb ^ (W'($urandom) & ((W'(1) << (4 * pos)) - W'(1)));
            end
            model(ra, rb, exp);
            applyStimulus(ra, rb, m, busy_err, flag_err);
            checkResult($sformatf("rand%0d", n), exp, m, busy_err, flag_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
